// File: rtl/multi_pulse_generator.sv
// ---------------------------------------------------------------------------
// multi_pulse_generator
//
// Purpose: CHANNELS independent pulse generators. Each channel runs either
// free-running (periodic) or for a counted burst of pulses, emitting a
// one-cycle registered pulse every latched_ticks cycles while in RUN.
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        asynchronous active-low reset
//   ena        per-channel enable (dropping it aborts a running channel)
//   mode       per-channel mode: 0 = periodic, 1 = burst
//   start      per-channel burst trigger (burst mode, IDLE only)
//   ticks      per-channel period, channel c at [c*N +: N]
//   burst_len  per-channel pulse count, channel c at [c*M +: M]
//   out        per-channel one-cycle pulse
//   busy       per-channel high while in RUN
//   done       per-channel one-cycle burst-completion pulse
//
// Channel FSM:
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | waiting for enable (+ start in burst mode), outputs low
//   ST_RUN  | period counter running, pulse emitted at each wrap
// ---------------------------------------------------------------------------
module multi_pulse_generator #(
    parameter int N        = 8,
    parameter int CHANNELS = 4,
    parameter int M        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   ena,
    input  logic [CHANNELS-1:0]   mode,
    input  logic [CHANNELS-1:0]   start,
    input  logic [CHANNELS*N-1:0] ticks,
    input  logic [CHANNELS*M-1:0] burst_len,
    output logic [CHANNELS-1:0]   out,
    output logic [CHANNELS-1:0]   busy,
    output logic [CHANNELS-1:0]   done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t         state_q, state_d;
        logic           mode_q, mode_d;
        logic [N-1:0]   tick_lat_q, tick_lat_d;
        logic [N-1:0]   per_cnt_q, per_cnt_d;
        logic [M-1:0]   len_lat_q, len_lat_d;
        logic [M-1:0]   pls_cnt_q, pls_cnt_d;
        logic           out_q, out_d;
        logic           done_q, done_d;

        logic [N-1:0]   ticks_c;
        logic [M-1:0]   len_c;
        logic           wrap;
        logic           last_pulse;

        assign ticks_c    = ticks[c*N +: N];
        assign len_c      = burst_len[c*M +: M];
        assign wrap       = (per_cnt_q == (tick_lat_q - N'(1)));
        assign last_pulse = mode_q && ((pls_cnt_q + M'(1)) == len_lat_q);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q    <= ST_IDLE;
                mode_q     <= 1'b0;
                tick_lat_q <= '0;
                per_cnt_q  <= '0;
                len_lat_q  <= '0;
                pls_cnt_q  <= '0;
                out_q      <= 1'b0;
                done_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                mode_q     <= mode_d;
                tick_lat_q <= tick_lat_d;
                per_cnt_q  <= per_cnt_d;
                len_lat_q  <= len_lat_d;
                pls_cnt_q  <= pls_cnt_d;
                out_q      <= out_d;
                done_q     <= done_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            mode_d     = mode_q;
            tick_lat_d = tick_lat_q;
            per_cnt_d  = per_cnt_q;
            len_lat_d  = len_lat_q;
            pls_cnt_d  = pls_cnt_q;
            out_d      = 1'b0;
            done_d     = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // start is only meaningful for burst mode; periodic
                    // channels launch on enable alone.
                    if (ena[c] && (ticks_c != '0) &&
                        (!mode[c] || (start[c] && (len_c != '0)))) begin
                        state_d    = ST_RUN;
                        mode_d     = mode[c];
                        tick_lat_d = ticks_c;
                        len_lat_d  = len_c;
                        per_cnt_d  = '0;
                        pls_cnt_d  = '0;
                    end
                end
                ST_RUN: begin
                    if (!ena[c]) begin
                        // Abort has priority over a coincident wrap.
                        state_d   = ST_IDLE;
                        per_cnt_d = '0;
                        pls_cnt_d = '0;
                    end else if (wrap) begin
                        per_cnt_d  = '0;
                        out_d      = 1'b1;
                        tick_lat_d = ticks_c;
                        pls_cnt_d  = pls_cnt_q + M'(1);
                        if (last_pulse) begin
                            state_d   = ST_IDLE;
                            done_d    = 1'b1;
                            pls_cnt_d = '0;
                        end else if (ticks_c == '0) begin
                            // A zero period cannot be counted; stop quietly.
                            state_d   = ST_IDLE;
                            pls_cnt_d = '0;
                        end
                    end else begin
                        per_cnt_d = per_cnt_q + N'(1);
                    end
                end
            endcase
        end

        assign out[c]  = out_q;
        assign done[c] = done_q;
        assign busy[c] = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_multi_pulse_generator.sv
module tb_multi_pulse_generator;

    localparam int N  = 8;
    localparam int CH = 4;
    localparam int M  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   ena, mode, start;
    logic [CH*N-1:0] ticks;
    logic [CH*M-1:0] burst_len;
    logic [CH-1:0]   out, busy, done;

    multi_pulse_generator #(.N(N), .CHANNELS(CH), .M(M)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .start(start),
        .ticks(ticks), .burst_len(burst_len),
        .out(out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: each running channel keeps the absolute edge number
    // of its next pulse and the number of burst pulses still owed.
    int            now = 0;
    bit            m_run   [CH];
    bit            m_bmode [CH];
    int            m_next  [CH];
    int            m_left  [CH];
    logic [CH-1:0] e_out, e_busy, e_done;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) m_run[c] = 1'b0;
        e_out = '0; e_busy = '0; e_done = '0;
    endtask

    task automatic model_edge();
        now++;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < CH; c++) begin
            int tk, ln;
            tk = int'(ticks[c*N +: N]);
            ln = int'(burst_len[c*M +: M]);
            e_out[c]  = 1'b0;
            e_done[c] = 1'b0;
            if (!m_run[c]) begin
                if (ena[c] && tk != 0 && (!mode[c] || (start[c] && ln != 0))) begin
                    m_run[c]   = 1'b1;
                    m_bmode[c] = mode[c];
                    m_next[c]  = now + tk;
                    m_left[c]  = ln;
                end
            end else if (!ena[c]) begin
                m_run[c] = 1'b0;
            end else if (now == m_next[c]) begin
                e_out[c]  = 1'b1;
                m_next[c] = now + tk;
                if (m_bmode[c]) begin
                    m_left[c]--;
                    if (m_left[c] == 0) begin
                        m_run[c]  = 1'b0;
                        e_done[c] = 1'b1;
                    end
                end
                if (tk == 0) m_run[c] = 1'b0;
            end
            e_busy[c] = m_run[c];
        end
    endtask

    task automatic checkv(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, now, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        checkv("out", out, e_out);
        checkv("busy", busy, e_busy);
        checkv("done", done, e_done);
    endtask

    task automatic set_ticks(input int c, input int v);
        ticks[c*N +: N] = N'(v);
    endtask

    task automatic set_len(input int c, input int v);
        burst_len[c*M +: M] = M'(v);
    endtask

    initial begin
        int cnt, dk;
        int q[$];

        rst = 1'b0; ena = '0; mode = '0; start = '0; ticks = '0; burst_len = '0;
        model_reset();
        #1;
        checkv("reset_out", out, '0);
        checkv("reset_busy", busy, '0);
        checkv("reset_done", done, '0);
        step(); step();
        rst = 1'b1;
        step();

        // Periodic ch0, ticks=120: 10 pulses in 1200 cycles after entry.
        set_ticks(0, 120); ena[0] = 1'b1;
        step();
        checki("p120_busy_entry", int'(busy[0]), 1);
        cnt = 0; dk = 0;
        for (int k = 1; k <= 1200; k++) begin
            step();
            if (out[0]) begin
                cnt++;
                if (dk == 0) dk = k;
            end
        end
        checki("p120_count", cnt, 10);
        checki("p120_first", dk, 120);

        // Abort 60 cycles into a period.
        for (int k = 0; k < 60; k++) step();
        ena[0] = 1'b0;
        step();
        checki("abort_busy", int'(busy[0]), 0);
        cnt = 0;
        for (int k = 0; k < 150; k++) begin
            step();
            if (out[0] || done[0]) cnt++;
        end
        checki("abort_quiet", cnt, 0);

        // Burst ch1: ticks=5, len=3, single-cycle start.
        set_ticks(1, 5); set_len(1, 3); mode[1] = 1'b1; ena[1] = 1'b1; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        q.delete(); dk = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (out[1]) q.push_back(k);
            if (done[1]) dk = k;
        end
        checki("burst_npulses", q.size(), 3);
        if (q.size() == 3) begin
            checki("burst_p1", q[0], 5);
            checki("burst_p2", q[1], 10);
            checki("burst_p3", q[2], 15);
        end
        checki("burst_done_at", dk, 15);
        checki("burst_busy_after", int'(busy[1]), 0);

        // Start held high: bursts retrigger back to back.
        set_ticks(1, 2); set_len(1, 2); start[1] = 1'b1;
        for (int k = 0; k < 20; k++) step();
        start[1] = 1'b0; ena[1] = 1'b0;
        step();

        // ticks=0 never leaves IDLE; ticks=1 pulses every cycle.
        set_ticks(2, 0); ena[2] = 1'b1;
        set_ticks(3, 1); ena[3] = 1'b1;
        step();
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (busy[2]) cnt++;
            if (out[3]) cnt += 100;
        end
        checki("t0_idle_t1_cont", cnt, 1500);
        ena[2] = 1'b0; ena[3] = 1'b0;
        step();

        // Period update 10 -> 4 mid-period.
        set_ticks(0, 10); ena[0] = 1'b1;
        step();
        for (int k = 1; k <= 5; k++) step();
        set_ticks(0, 4);
        q.delete();
        for (int k = 6; k <= 25; k++) begin
            step();
            if (out[0]) q.push_back(k);
        end
        checki("upd_npulses", q.size(), 4);
        if (q.size() >= 3) begin
            checki("upd_p1", q[0], 10);
            checki("upd_p2", q[1], 14);
            checki("upd_p3", q[2], 18);
        end
        ena[0] = 1'b0;
        step();

        // All four channels periodic 3/4/5/7, then async reset between edges.
        mode = '0;
        set_ticks(0, 3); set_ticks(1, 4); set_ticks(2, 5); set_ticks(3, 7);
        ena = '1;
        for (int k = 0; k < 60; k++) step();
        #2 rst = 1'b0;
        model_reset();
        #1;
        checkv("async_out", out, '0);
        checkv("async_busy", busy, '0);
        checkv("async_done", done, '0);
        #1 rst = 1'b1;
        for (int k = 0; k < 40; k++) step();

        // Randomised traffic checked against the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 29) == 0) ena[c] = ~ena[c];
                else if (!ena[c] && $urandom_range(0, 3) == 0) ena[c] = 1'b1;
                start[c] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 15) == 0) set_ticks(c, int'($urandom_range(0, 9)));
                if ($urandom_range(0, 15) == 0) set_len(c, int'($urandom_range(0, 5)));
                if ($urandom_range(0, 31) == 0) mode[c] = ~mode[c];
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
